lcd_text_formatter: RTL and testbench

- Upstream feeder for the character-LCD controller. Takes a 16-bit unsigned value and renders it as ASCII decimal into the 2x16 line buffers (line1, line2).
- Issues the refresh request with timing the controller can sample: the controller samples refresh only on its 1 MHz tick, and its ready never drops during a write.
- Keeps line buffers stable for the whole write window. Coalesces rapid value updates so only the most recent one is displayed.

---
 rtl/lcd_text_formatter.sv | 181 ++++++++++++++++++
 tb/tb_lcd_text_formatter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_formatter.sv
// Renders a 16-bit value as right-aligned decimal on line 2 of a 2x16 LCD and
// paces refresh requests for the controller. Optional hex suffix: LCD_FMT_HEX_EN.
module lcd_text_formatter #(
  parameter logic [127:0] BANNER       = 128'h2020_4C43_4420_2043_4F55_4E54_4552_2020,
  parameter logic [47:0]  LABEL        = 48'h434F_554E_543A,
  parameter int           REFRESH_HOLD = 200,
  parameter int           MIN_GAP      = 250000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  value_in,
  input  logic         value_valid,
  input  logic         lcd_ready,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         refresh,
  output logic         busy,
  output logic         pending
);

  // Handshake: value_valid is a one-cycle strobe with no backpressure; refresh
  // is held for REFRESH_HOLD cycles while lcd_ready stays high, else retried.
  typedef enum logic [2:0] {
    IDLE, CONVERT, FORMAT, WAIT_READY, HOLD, GAP
  } state_t;

  localparam int CNT_MAX = (MIN_GAP > REFRESH_HOLD) ? MIN_GAP : REFRESH_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REFRESH_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MIN_GAP - 1);

  state_t            state_q, state_d;
  logic [15:0]       pend_val_q, pend_val_d;
  logic              pending_q, pending_d;
  logic [15:0]       shift_q, shift_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [3:0]        iter_q, iter_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [127:0]      line2_q, line2_d;
  logic              refresh_q, refresh_d;
`ifdef LCD_FMT_HEX_EN
  logic [15:0]       hex_q, hex_d;
  logic [3:0]        nib;
`endif

  logic [19:0]       bcd_adj;
  logic [35:0]       dd_shifted;
  logic [3:0]        digit;
  logic              seen_nz;
  logic              take_direct;

  // In IDLE with nothing queued a fresh strobe starts converting immediately.
  assign take_direct = (state_q == IDLE) && !pending_q && value_valid;

  always_comb begin
    state_d    = state_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    cnt_d      = cnt_q;
    line2_d    = line2_q;
    refresh_d  = 1'b0;
    bcd_adj    = bcd_q;
    dd_shifted = '0;
    digit      = '0;
    seen_nz    = 1'b0;
`ifdef LCD_FMT_HEX_EN
    hex_d      = hex_q;
    nib        = '0;
`endif

    case (state_q)
      IDLE: begin
        if (pending_q || value_valid) begin
          state_d   = CONVERT;
          bcd_d     = '0;
          iter_d    = '0;
          shift_d   = pending_q ? pend_val_q : value_in;
          pending_d = 1'b0;
`ifdef LCD_FMT_HEX_EN
          hex_d     = pending_q ? pend_val_q : value_in;
`endif
        end
      end
      CONVERT: begin
        for (int i = 0; i < 5; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        dd_shifted = {bcd_adj, shift_q} << 1;
        bcd_d      = dd_shifted[35:16];
        shift_d    = dd_shifted[15:0];
        iter_d     = iter_q + 4'd1;
        if (iter_q >= 4'd15) state_d = FORMAT;
      end
      FORMAT: begin
        line2_d          = {16{8'h20}};
        line2_d[127:80]  = LABEL;
        for (int i = 4; i >= 0; i--) begin
          digit   = bcd_q[4*i +: 4];
          seen_nz = seen_nz || (digit != 4'd0) || (i == 0);
          line2_d[8*i+40 +: 8] = seen_nz ? {4'h3, digit} : 8'h20;
        end
`ifdef LCD_FMT_HEX_EN
        for (int n = 0; n < 4; n++) begin
          nib = hex_q[4*n +: 4];
          line2_d[8*n +: 8] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end
`endif
        state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (lcd_ready) begin
          state_d   = HOLD;
          cnt_d     = '0;
          refresh_d = 1'b1;
        end
      end
      HOLD: begin
        if (!lcd_ready) begin
          state_d = WAIT_READY;
        end else if (cnt_q >= HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          refresh_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Latest strobe always wins the pending slot unless consumed directly.
    if (value_valid && !take_direct) begin
      pend_val_d = value_in;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      cnt_q      <= '0;
      line2_q    <= {16{8'h20}};
      refresh_q  <= 1'b0;
`ifdef LCD_FMT_HEX_EN
      hex_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      cnt_q      <= cnt_d;
      line2_q    <= line2_d;
      refresh_q  <= refresh_d;
`ifdef LCD_FMT_HEX_EN
      hex_q      <= hex_d;
`endif
    end
  end

  assign line1   = BANNER;
  assign line2   = line2_q;
  assign refresh = refresh_q;
  assign busy    = (state_q != IDLE);
  assign pending = pending_q;

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Scoreboarded bench for lcd_text_formatter: expected line2 images are queued at
// stimulus time and popped by a monitor whenever line2 changes.
module tb_lcd_text_formatter;

  localparam int RH = 200;
  localparam int MG = 400;
  localparam logic [127:0] BANNER = 128'h2020_4C43_4420_2043_4F55_4E54_4552_2020;
  localparam logic [127:0] SPACES = {16{8'h20}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [15:0]  value_in = '0;
  logic         value_valid = 1'b0;
  logic         lcd_ready = 1'b1;
  logic [127:0] line1, line2;
  logic         refresh, busy, pending;

  lcd_text_formatter #(.REFRESH_HOLD(RH), .MIN_GAP(MG)) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .value_valid(value_valid),
    .lcd_ready(lcd_ready), .line1(line1), .line2(line2), .refresh(refresh),
    .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];
  logic [127:0] prev_line2 = {16{8'h20}};
  logic [127:0] shown = {16{8'h20}};
  int hi_cnt = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [15:0] last_v = 16'hFFFF;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference image built from decimal arithmetic on the value.
  function automatic logic [127:0] model(input int v);
    logic [127:0] r;
    int p, d;
    r = {16{8'h20}};
    r[127:80] = 48'h434F_554E_543A;
    p = 10000;
    for (int k = 0; k < 5; k++) begin
      d = (v / p) % 10;
      if (v >= p || k == 4) r[127 - 8*(6+k) -: 8] = 8'(8'h30 + d);
      p = p / 10;
    end
`ifdef LCD_FMT_HEX_EN
    for (int k = 0; k < 4; k++) begin
      d = (v >> (12 - 4*k)) & 15;
      r[127 - 8*(12+k) -: 8] = (d < 10) ? 8'(8'h30 + d) : 8'(8'h41 + d - 10);
    end
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (line2 !== prev_line2) begin
      if (exp_q.size() == 0) check("unexpected_line2", line2, prev_line2);
      else check("line2", line2, exp_q.pop_front());
      prev_line2 = line2;
    end
    if (!reset_n) hi_cnt = 0;
    else if (refresh) hi_cnt++;
    else if (hi_cnt > 0) begin
      check("refresh_width", 128'(hi_cnt), 128'(RH));
      pulses++;
      hi_cnt = 0;
    end
  end

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    value_in = v;
    value_valid = 1'b1;
    @(posedge clk);
    #1 value_valid = 1'b0;
  endtask

  // Issue a value that will be converted on its own and displayed.
  task automatic issue(input logic [15:0] v);
    exp_q.push_back(model(int'(v)));
    shown = model(int'(v));
    exp_pulses++;
    last_v = v;
    strobe(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || pending) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 5000) check("idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic latency_test(input logic [15:0] v);
    logic [127:0] old;
    old = shown;
    issue(v);
    repeat (16) @(posedge clk);
    #1 check("line2_before_N17", line2, old);
    @(posedge clk);
    #1 check("line2_at_N17", line2, model(int'(v)));
    check("refresh_low_N17", 128'(refresh), 128'(0));
    @(posedge clk);
    #1 check("refresh_rise_N18", 128'(refresh), 128'(1));
    repeat (RH - 1) @(posedge clk);
    #1 check("refresh_still_high", 128'(refresh), 128'(1));
    @(posedge clk);
    #1 check("refresh_fall", 128'(refresh), 128'(0));
    check("busy_in_gap", 128'(busy), 128'(1));
    wait_idle();
    check("busy_after_gap", 128'(busy), 128'(0));
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_line1", line1, BANNER);
    check("rst_line2", line2, SPACES);
    check("rst_refresh", 128'(refresh), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_pending", 128'(pending), 128'(0));
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    latency_test(16'd12345);
    latency_test(16'd0);
    latency_test(16'd65535);
    latency_test(16'd7);
    latency_test(16'd48879);

    // lcd_ready low: line2 updates but refresh waits.
    lcd_ready = 1'b0;
    issue(16'd42);
    repeat (30) @(posedge clk);
    #1 check("wait_line2", line2, model(42));
    check("wait_refresh_low", 128'(refresh), 128'(0));
    repeat (1000) @(posedge clk);
    #1 check("wait_refresh_still_low", 128'(refresh), 128'(0));
    @(negedge clk) lcd_ready = 1'b1;
    @(posedge clk);
    #1 check("ready_refresh_rise", 128'(refresh), 128'(1));
    wait_idle();

    // Coalescing during GAP.
    issue(16'd300);
    repeat (17 + 1 + RH + 20) @(posedge clk);
    strobe(16'd100);
    exp_q.push_back(model(200));
    shown = model(200);
    exp_pulses++;
    last_v = 16'd200;
    strobe(16'd200);
    #1 check("gap_pending", 128'(pending), 128'(1));
    check("gap_line2_frozen", line2, model(300));
    repeat (100) @(posedge clk);
    #1 check("gap_line2_still", line2, model(300));
    wait_idle();

    // Reset mid-HOLD.
    exp_q.push_back(model(500));
    strobe(16'd500);
    repeat (30) @(posedge clk);
    #1 check("hold_refresh_high", 128'(refresh), 128'(1));
    exp_q.push_back(SPACES);
    shown = SPACES;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_refresh", 128'(refresh), 128'(0));
    check("rst_mid_line2", line2, SPACES);
    check("rst_mid_line1", line1, BANNER);
    check("rst_mid_pending", 128'(pending), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      if (v == last_v) v = v + 16'd1;
      if ($urandom_range(0, 3) == 0) begin
        lcd_ready = 1'b0;
        issue(v);
        repeat ($urandom_range(20, 60)) @(posedge clk);
        @(negedge clk) lcd_ready = 1'b1;
      end else begin
        issue(v);
      end
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    check("pulse_count", 128'(pulses), 128'(exp_pulses));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
